// File: rtl/axi_lite_datmem_slave.sv
// AXI4-Lite slave in front of a byte-strobed, word-organised data memory.
// Optional wait states before BVALID/RVALID: define DATMEM_WAIT_STATES_EN.
module axi_lite_datmem_slave #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        ACLK,
    input  logic        ARSTN,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY
);

    localparam int unsigned IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    logic [31:0] mem [DEPTH];

    w_state_t    w_state;
    r_state_t    r_state;
    logic        aw_cap;
    logic        w_cap;
    logic [31:0] aw_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;

    logic        aw_hs;
    logic        w_hs;
    logic        commit;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] wr_off;
    logic        wr_ok;
    logic [IW-1:0] wr_idx;
    logic [31:0] rd_off;
    logic        rd_ok;
    logic [IW-1:0] rd_idx;

`ifdef DATMEM_WAIT_STATES_EN
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] r_cnt;
`else
    // WAIT_CYCLES has no effect without wait states
    if (WAIT_CYCLES > 32'hFFFF) begin : g_wait_unused
    end
`endif

    assign aw_hs   = AWVALID & AWREADY;
    assign w_hs    = WVALID & WREADY;
    assign wr_addr = aw_cap ? aw_addr : AWADDR;
    assign wr_data = w_cap ? w_data : WDATA;
    assign wr_strb = w_cap ? w_strb : WSTRB;
    assign commit  = (w_state == W_IDLE) & (aw_cap | aw_hs) & (w_cap | w_hs);

    assign wr_off = wr_addr - BASE_ADDR;
    assign wr_ok  = wr_off < SPAN;
    assign wr_idx = wr_off[IW+1:2];
    assign rd_off = ARADDR - BASE_ADDR;
    assign rd_ok  = rd_off < SPAN;
    assign rd_idx = rd_off[IW+1:2];

    // Gated by ARSTN so no write can land while reset is asserted
    always_ff @(posedge ACLK) begin
        if (commit && wr_ok && ARSTN) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            w_state <= W_IDLE;
            aw_cap  <= 1'b0;
            w_cap   <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            BVALID  <= 1'b0;
            BRESP   <= OKAY;
`ifdef DATMEM_WAIT_STATES_EN
            w_cnt   <= '0;
`endif
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        aw_cap  <= 1'b1;
                        w_cap   <= 1'b1;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b0;
                        BRESP   <= wr_ok ? OKAY : SLVERR;
`ifdef DATMEM_WAIT_STATES_EN
                        w_cnt   <= CW'(WAIT_CYCLES - 1);
                        w_state <= W_WAIT;
`else
                        BVALID  <= 1'b1;
                        w_state <= W_RESP;
`endif
                    end else begin
                        if (aw_hs) begin
                            aw_cap  <= 1'b1;
                            aw_addr <= AWADDR;
                            AWREADY <= 1'b0;
                        end
                        if (w_hs) begin
                            w_cap  <= 1'b1;
                            w_data <= WDATA;
                            w_strb <= WSTRB;
                            WREADY <= 1'b0;
                        end
                    end
                end
`ifdef DATMEM_WAIT_STATES_EN
                W_WAIT: begin
                    if (w_cnt == '0) begin
                        BVALID  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 1'b1;
                    end
                end
`endif
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        aw_cap  <= 1'b0;
                        w_cap   <= 1'b0;
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // RDATA is sampled at the AR edge, so a same-edge write is not visible
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b1;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= OKAY;
`ifdef DATMEM_WAIT_STATES_EN
            r_cnt   <= '0;
`endif
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (ARVALID) begin
                        RDATA   <= rd_ok ? mem[rd_idx] : '0;
                        RRESP   <= rd_ok ? OKAY : SLVERR;
                        ARREADY <= 1'b0;
`ifdef DATMEM_WAIT_STATES_EN
                        r_cnt   <= CW'(WAIT_CYCLES - 1);
                        r_state <= R_WAIT;
`else
                        RVALID  <= 1'b1;
                        r_state <= R_DATA;
`endif
                    end
                end
`ifdef DATMEM_WAIT_STATES_EN
                R_WAIT: begin
                    if (r_cnt == '0) begin
                        RVALID  <= 1'b1;
                        r_state <= R_DATA;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                R_DATA: begin
                    if (RREADY) begin
                        RVALID  <= 1'b0;
                        ARREADY <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_datmem_slave.sv
// Directed self-checking bench for axi_lite_datmem_slave.
// Expected latencies follow DATMEM_WAIT_STATES_EN with WAIT_CYCLES=2.
module tb_axi_lite_datmem_slave;

`ifdef DATMEM_WAIT_STATES_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        ACLK = 1'b0;
    logic        ARSTN = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;

    int errors = 0;
    int checks = 0;

    axi_lite_datmem_slave #(
        .DEPTH(1024),
        .BASE_ADDR(32'h0),
        .WAIT_CYCLES(2)
    ) dut (
        .ACLK(ACLK), .ARSTN(ARSTN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_b(input string tag);
        int lat = 1;
        while (!BVALID && lat < 20) begin
            tick();
            lat++;
        end
        chk(tag, 32'(lat), 32'(EXP_LAT));
    endtask

    task automatic wait_r(input string tag);
        int lat = 1;
        while (!RVALID && lat < 20) begin
            tick();
            lat++;
        end
        chk(tag, 32'(lat), 32'(EXP_LAT));
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp);
        AWADDR  = a;
        WDATA   = d;
        WSTRB   = s;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        BREADY  = 1'b1;
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        wait_b("wr_lat");
        chk("bresp", 32'(BRESP), 32'(resp));
        tick();
        chk("b_done", 32'({BVALID, AWREADY, WREADY}), 32'h3);
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] resp);
        ARADDR  = a;
        ARVALID = 1'b1;
        RREADY  = 1'b0;
        tick();
        ARVALID = 1'b0;
        wait_r("rd_lat");
        chk("rdata", RDATA, d);
        chk("rresp", 32'(RRESP), 32'(resp));
        RREADY = 1'b1;
        tick();
        chk("r_done", 32'({RVALID, ARREADY}), 32'h1);
        RREADY = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ready", 32'({AWREADY, WREADY, ARREADY}), 32'h7);
        chk("rst_valid", 32'({BVALID, RVALID}), 32'h0);
        chk("rst_rdata", RDATA, 32'h0);
        ARSTN = 1'b1;
        tick();

        // same-cycle AW and W, then read back
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
        do_read(32'h10, 32'hDEADBEEF, 2'b00);

        // W three cycles ahead of AW, byte 0 only
        WDATA  = 32'h0000_00AA;
        WSTRB  = 4'b0001;
        WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("w_early_wready", 32'(WREADY), 32'h0);
        chk("w_early_awready", 32'(AWREADY), 32'h1);
        tick();
        tick();
        chk("w_early_nob", 32'(BVALID), 32'h0);
        AWADDR  = 32'h10;
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        wait_b("w_early_lat");
        chk("w_early_bresp", 32'(BRESP), 32'h0);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        do_read(32'h10, 32'hDEADBEAA, 2'b00);

        // out-of-range write and read
        do_write(32'h0, 32'h0, 4'hF, 2'b00);
        do_write(32'h1000, 32'h5555_5555, 4'hF, 2'b10);
        do_read(32'h0, 32'h0, 2'b00);
        do_read(32'h1000, 32'h0, 2'b10);

        // B held off for 5 cycles
        AWADDR  = 32'h30;
        WDATA   = 32'h0BAD_F00D;
        WSTRB   = 4'hF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        BREADY  = 1'b0;
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        wait_b("hold_lat");
        for (int i = 0; i < 5; i++) begin
            chk("hold_bvalid", 32'(BVALID), 32'h1);
            chk("hold_bresp", 32'(BRESP), 32'h0);
            chk("hold_ready", 32'({AWREADY, WREADY}), 32'h0);
            tick();
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("hold_release", 32'({BVALID, AWREADY, WREADY}), 32'h3);
        do_read(32'h30, 32'h0BAD_F00D, 2'b00);

        // same-edge commit and AR to one word returns old data
        do_write(32'h20, 32'h0, 4'hF, 2'b00);
        AWADDR  = 32'h20;
        WDATA   = 32'h1234_5678;
        WSTRB   = 4'hF;
        ARADDR  = 32'h20;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARVALID = 1'b0;
        wait_r("same_lat");
        chk("same_rdata", RDATA, 32'h0);
        chk("same_bvalid", 32'(BVALID), 32'h1);
        BREADY = 1'b1;
        RREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        RREADY = 1'b0;
        chk("same_done", 32'({BVALID, RVALID}), 32'h0);
        do_read(32'h20, 32'h1234_5678, 2'b00);

        // all strobes off: no change, OKAY
        do_write(32'h20, 32'hFFFF_FFFF, 4'h0, 2'b00);
        do_read(32'h20, 32'h1234_5678, 2'b00);

        // partial strobe on upper bytes
        do_write(32'h20, 32'hAABB_CCDD, 4'b1100, 2'b00);
        do_read(32'h22, 32'hAABB_5678, 2'b00);

        // async reset while in R_DATA
        ARADDR  = 32'h20;
        ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        wait_r("rst_mid_lat");
        chk("rst_mid_rvalid_pre", 32'(RVALID), 32'h1);
        ARSTN = 1'b0;
        #1;
        chk("rst_mid_rvalid", 32'(RVALID), 32'h0);
        chk("rst_mid_arready", 32'(ARREADY), 32'h1);
        chk("rst_mid_rdata", RDATA, 32'h0);
        #2;
        ARSTN = 1'b1;
        tick();
        do_read(32'h10, 32'hDEADBEAA, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_datmem_slave.md
Name: axi_lite_datmem_slave

Overview:
AXI4-Lite responder fronting a word-organised data memory. It is the far end of the pipeline's data-memory AXI4-Lite master. It accepts write address and write data in either order, commits byte-strobed writes, and returns B responses. It accepts read addresses and returns registered read data with an R response. Out-of-range accesses complete with SLVERR so the master's error output fires.

Parameters:
DEPTH, 1024, number of 32-bit words in the memory array (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned)
WAIT_CYCLES, 2, extra stall cycles before BVALID/RVALID (used only with the optional feature)

Ports:
ACLK  in  1  clock, all state on rising edge
ARSTN  in  1  reset; one clock; reset is asynchronous and active-low
AWADDR  in  32  write byte address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  32  write data
WSTRB  in  4  byte enables, bit i -> WDATA[8i+7:8i]
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response, 2'b00 OKAY / 2'b10 SLVERR
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  32  read byte address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  32  read data
RRESP  out  2  read response, 2'b00 / 2'b10
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
- Reset (async assert, sync release): AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0. Write FSM goes to W_IDLE, read FSM to R_IDLE, capture flags cleared. Memory contents are not cleared.
- Reset mid-transaction: any in-flight capture or response is dropped. A write is never partially committed; a commit happens only on a clock edge with ARSTN high.
- Address decode: off = addr - BASE_ADDR. In range iff off < DEPTH*4. Word index = off[log2(DEPTH)+1:2]. addr[1:0] are ignored.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: AWREADY = ~aw_cap; WREADY = ~w_cap.
  - An AW handshake latches AWADDR and sets aw_cap. A W handshake latches WDATA/WSTRB and sets w_cap.
  - Both handshakes in the same cycle are legal. Either order is legal, with any gap between them.
  - On the edge where both are held or arriving: commit, then go to W_RESP. Commit means: if in range, write the bytes whose strobe is 1 and leave other bytes unchanged. If out of range, discard the write.
  - W_RESP: AWREADY=0, WREADY=0, BVALID=1, BRESP = in range ? 00 : 10. Hold until BREADY. On the BVALID&BREADY edge, clear both caps and return to W_IDLE.
  - Write commit-to-BVALID latency: 1 cycle.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, register RDATA = mem[idx] (0 if out of range) and RRESP = 00 or 10, then go to R_DATA.
  - R_DATA: ARREADY=0, RVALID=1. RDATA and RRESP are stable until RREADY. On the RVALID&RREADY edge, return to R_IDLE.
  - AR-to-RVALID latency: 1 cycle.
- Read and write channels are independent and may be active concurrently.
- Same-edge write commit and AR handshake to the same word: RDATA returns the pre-write value. The next read sees the new value.
- WSTRB=0000 in range: no bytes change, BRESP=00.
- Back-to-back: a new AR is accepted on the cycle after the R handshake. A new AW/W is accepted on the cycle after the B handshake. There is no combinational path from any VALID to its own READY.

Optional Feature:
Macro: DATMEM_WAIT_STATES_EN.
- Defined: a WAIT_CYCLES-deep counter is added per channel. W_WAIT is inserted between commit and W_RESP, and R_WAIT between the AR handshake and R_DATA. BVALID and RVALID assert WAIT_CYCLES+1 cycles after commit or AR. The commit and the RDATA sampling point are unchanged. The counter reloads on every entry and is cleared by reset.
- Undefined: no counter logic; latencies are exactly 1 cycle.

Test Plan:
- AW 0x10 and W 0xDEADBEEF/1111 in the same cycle, BREADY=1 -> BVALID 1 cycle after commit, BRESP=00. Then AR 0x10 -> RDATA=0xDEADBEEF, RRESP=00.
- W 0x000000AA/0001 three cycles before AW 0x10 -> WREADY low after the W handshake. The commit yields mem word = 0xDEADBEAA.
- AW 0x1000 with DEPTH=1024 (out of range) -> BRESP=10 and the memory is unchanged. AR 0x1000 -> RDATA=0, RRESP=10.
- Hold BREADY=0 for 5 cycles -> BVALID and BRESP stable, AWREADY=WREADY=0. Release -> W_IDLE on the next cycle.
- Same-edge write of 0x12345678 to 0x20 (old value 0x0) and AR 0x20 -> RDATA=0x0. A following read returns 0x12345678.
- ARSTN pulsed low while in R_DATA with RREADY=0 -> RVALID=0 immediately, ARREADY=1. With DATMEM_WAIT_STATES_EN and WAIT_CYCLES=2, RVALID asserts 3 cycles after AR.
